// File: rtl/main_fsm.sv
// Main control FSM for the multi-cycle RV32I datapath.
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback, one state per clock, and drives the datapath enables and mux
// selects. All outputs except `illegal` are registered alongside the state,
// so they only change on clock edges (or immediately on reset).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, forces FETCH
//   op        in   instr[6:0] from the instruction register
//   branch    out  conditional PC update request
//   pcupdate  out  unconditional PC write
//   regwrite  out  register file write enable
//   memwrite  out  data memory write enable
//   irwrite   out  instruction register / OldPC load
//   resultsrc out  result mux: 00 ALUOut, 01 Data, 10 ALUResult
//   alusrca   out  ALU A: 00 PC, 01 OldPC, 10 rs1
//   alusrcb   out  ALU B: 00 rs2, 01 ImmExt, 10 constant 4
//   adrsrc    out  memory address: 0 PC, 1 Result
//   aluop     out  ALU decoder op: 00 add, 01 sub, 10 funct decode
//   illegal   out  high in DECODE when op is unsupported
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       branch,
  output logic       pcupdate,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       adrsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       pcupdate;
    logic       regwrite;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic       adrsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // Control word for a given state; unused encodings decode to all zeros.
  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.irwrite   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.pcupdate  = 1'b1;
      end
      StDecode: begin
        // Precompute branch/jump target from OldPC + imm.
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      StMemAdr: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      StMemRead: begin
        c.adrsrc = 1'b1;
      end
      StMemWb: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      StMemWrite: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      StExecuteR: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      StExecuteI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      StAluWb: begin
        c.regwrite = 1'b1;
      end
      StBeq: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
      end
      StJal: begin
        // Link value OldPC + 4 computed here; target was latched in DECODE.
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (op == OpLoad) begin
          state_d = StMemRead;
        end else if (op == OpStore) begin
          state_d = StMemWrite;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Control word is registered from the next state so it tracks state_q
  // exactly and never glitches within a state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= ctrl_of(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  always_comb begin
    branch    = ctrl_q.branch;
    pcupdate  = ctrl_q.pcupdate;
    regwrite  = ctrl_q.regwrite;
    memwrite  = ctrl_q.memwrite;
    irwrite   = ctrl_q.irwrite;
    resultsrc = ctrl_q.resultsrc;
    alusrca   = ctrl_q.alusrca;
    alusrcb   = ctrl_q.alusrcb;
    adrsrc    = ctrl_q.adrsrc;
    aluop     = ctrl_q.aluop;
  end

  // op is held stable by the instruction register throughout DECODE.
  always_comb begin
    illegal = 1'b0;
    if (state_q == StDecode) begin
      case (op)
        OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal: illegal = 1'b0;
        default:                                            illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       branch, pcupdate, regwrite, memwrite, irwrite, adrsrc, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;

  int total = 0;
  int bad   = 0;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .branch    (branch),
    .pcupdate  (pcupdate),
    .regwrite  (regwrite),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .resultsrc (resultsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .adrsrc    (adrsrc),
    .aluop     (aluop),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Instruction steps, named after the spec's state list.
  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
  localparam int SER = 6, SEI = 7, SAW = 8, SB = 9, SJ = 10;

  function automatic string step_name(input int s);
    string n[11] = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB", "MEMWRITE",
                     "EXECUTER", "EXECUTEI", "ALUWB", "BEQ", "JAL"};
    return n[s];
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return o == 7'h03 || o == 7'h23 || o == 7'h33 || o == 7'h13 || o == 7'h63 || o == 7'h6f;
  endfunction

  // Step k of an instruction with opcode o; -1 once the next FETCH is due.
  function automatic int step_of(input logic [6:0] o, input int k);
    int s[5];
    int n;
    case (o)
      7'h03:   begin s = '{SF, SD, SMA, SMR, SMWB}; n = 5; end
      7'h23:   begin s = '{SF, SD, SMA, SMW, 0};    n = 4; end
      7'h33:   begin s = '{SF, SD, SER, SAW, 0};    n = 4; end
      7'h13:   begin s = '{SF, SD, SEI, SAW, 0};    n = 4; end
      7'h6f:   begin s = '{SF, SD, SJ, SAW, 0};     n = 4; end
      7'h63:   begin s = '{SF, SD, SB, 0, 0};       n = 3; end
      default: begin s = '{SF, SD, 0, 0, 0};        n = 2; end
    endcase
    if (k >= n) return -1;
    return s[k];
  endfunction

  // {branch,pcupdate,regwrite,memwrite,irwrite,resultsrc,alusrca,alusrcb,adrsrc,aluop}
  function automatic logic [13:0] mk(input logic b, input logic pc, input logic rw,
                                     input logic mw, input logic ir, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] bb,
                                     input logic ad, input logic [1:0] ao);
    return {b, pc, rw, mw, ir, rs, a, bb, ad, ao};
  endfunction

  function automatic logic [13:0] exp_ctrl(input int s);
    case (s)
      SF:      return mk(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 2'b00);
      SD:      return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00);
      SMA:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00);
      SMR:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00);
      SMWB:    return mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00);
      SMW:     return mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00);
      SER:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10);
      SEI:     return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10);
      SAW:     return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
      SB:      return mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01);
      SJ:      return mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00);
      default: return '0;
    endcase
  endfunction

  // Drive op (real opcode only where it is sampled, junk elsewhere), then check.
  task automatic check_cycle(input int s, input logic [6:0] opv, input string note);
    logic [14:0] obs, exp;
    if (s == SD || s == SMA) op = opv;
    else op = 7'($urandom);
    #1;
    obs = {branch, pcupdate, regwrite, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           adrsrc, aluop, illegal};
    exp = {exp_ctrl(s), (s == SD) && !is_legal(opv)};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s op=%b step=%s observed=%b expected=%b", note, opv, step_name(s), obs, exp);
    end
  endtask

  // Entered mid-cycle in FETCH; returns mid-cycle in the following FETCH.
  task automatic run_instr(input logic [6:0] opv, input string note);
    int k = 0;
    while (step_of(opv, k) >= 0) begin
      check_cycle(step_of(opv, k), opv, note);
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    logic [6:0] legal_ops[6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
    logic [6:0] r;

    reset = 1'b1;
    op    = 7'h00;
    repeat (2) @(posedge clk);
    #2;
    check_cycle(SF, 7'h00, "reset_hold");
    @(negedge clk);
    reset = 1'b0;

    run_instr(7'h03, "lw");
    run_instr(7'h23, "sw");
    run_instr(7'h33, "rtype");
    run_instr(7'h13, "itype");
    run_instr(7'h63, "beq");
    run_instr(7'h6f, "jal");
    run_instr(7'h7f, "illegal");

    // Async reset in MEMREAD: FETCH outputs must appear without a clock edge.
    for (int k = 0; k < 4; k++) begin
      check_cycle(step_of(7'h03, k), 7'h03, "lw_pre_reset");
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b1;
    check_cycle(SF, 7'h03, "async_reset");
    @(posedge clk);
    #1;
    check_cycle(SF, 7'h03, "reset_over_edge");
    @(negedge clk);
    reset = 1'b0;
    run_instr(7'h03, "lw_after_reset");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) r = 7'($urandom);
      else r = legal_ops[$urandom_range(0, 5)];
      run_instr(r, "random");
    end
    check_cycle(SF, 7'h00, "final_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Main control state machine for the multi-cycle RV32I datapath. It sequences every instruction through fetch, decode, execute, memory and writeback steps, one state per clock. It drives the datapath enables and mux selects, and produces the 2-bit `aluop` consumed by the ALU decoder, which turns it into `alucontrol`. Opcode is taken from the instruction register, which holds it stable from the end of FETCH until the next FETCH.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH.
- `op`  in  7  instr[6:0] from instruction register.
- `branch`  out  1  conditional PC update request (PC enable = `pcupdate | (branch & zero)`, formed outside).
- `pcupdate`  out  1  unconditional PC write.
- `regwrite`  out  1  register file write enable.
- `memwrite`  out  1  data memory write enable.
- `irwrite`  out  1  instruction register (and OldPC) load.
- `resultsrc`  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- `alusrca`  out  2  ALU A: 00 PC, 01 OldPC, 10 rs1 (A reg).
- `alusrcb`  out  2  ALU B: 00 rs2 (WriteData reg), 01 ImmExt, 10 constant 4.
- `adrsrc`  out  1  memory address: 0 PC, 1 Result.
- `aluop`  out  2  to ALU decoder: 00 add, 01 subtract, 10 decode funct fields.
- `illegal`  out  1  high while in DECODE with an unsupported opcode.

## Operation
- Moore FSM, 11 states, 4-bit state register. All outputs except `illegal` depend only on state. Any field not listed for a state is 0.
- FETCH: `adrsrc`=0, `irwrite`=1, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10, `pcupdate`=1.
- DECODE: `alusrca`=01, `alusrcb`=01, `aluop`=00. This state precomputes the branch/jump target.
- MEMADR: `alusrca`=10, `alusrcb`=01, `aluop`=00.
- MEMREAD: `resultsrc`=00, `adrsrc`=1.
- MEMWB: `resultsrc`=01, `regwrite`=1.
- MEMWRITE: `resultsrc`=00, `adrsrc`=1, `memwrite`=1.
- EXECUTER: `alusrca`=10, `alusrcb`=00, `aluop`=10.
- EXECUTEI: `alusrca`=10, `alusrcb`=01, `aluop`=10.
- ALUWB: `resultsrc`=00, `regwrite`=1.
- BEQ: `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00, `branch`=1.
- JAL: `alusrca`=01, `alusrcb`=10, `aluop`=00, `resultsrc`=00, `pcupdate`=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE on `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other → FETCH, with `illegal`=1 during that DECODE cycle.
  - MEMADR: `op`=0000011→MEMREAD; `op`=0100011→MEMWRITE; any other value (cannot occur) → FETCH.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI and JAL → ALUWB→FETCH.
  - BEQ→FETCH.
- Unused state encodings → FETCH next cycle. Outputs in an unused encoding are all 0.

## Timing
- Reset asserted, including mid-instruction: state becomes FETCH immediately, with no clock edge needed. Outputs then show FETCH values (`irwrite`=1, `pcupdate`=1, `alusrcb`=10, `resultsrc`=10, all other outputs 0). The first edge after deassertion moves to DECODE.
- `op` is sampled only on the edge leaving DECODE and the edge leaving MEMADR. It is don't-care elsewhere.
- Instruction latency, counted in cycles from FETCH to the next FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - jal 4
  - beq 3
  - illegal 2
- `aluop` changes only on clock edges, so the ALU decoder output is glitch-free within a state.

## Test plan
- Reset, then `op`=0000011 held: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. `regwrite`=1 and `resultsrc`=01 in cycle 5 only.
- `op`=0100011: 4-cycle sequence; `memwrite`=1 and `adrsrc`=1 in cycle 4 only; `regwrite` is never 1.
- `op`=0110011, then 0010011: `aluop`=10 in cycle 3 with `alusrcb`=00 and 01 respectively; ALUWB in cycle 4; next FETCH in cycle 5.
- `op`=1100011: cycle 3 shows `branch`=1, `aluop`=01, `pcupdate`=0; FETCH follows. `op`=1101111: cycle 3 shows `pcupdate`=1, `alusrca`=01, `alusrcb`=10; ALUWB in cycle 4.
- `op`=1111111: `illegal`=1 in DECODE only; FETCH next cycle; no `regwrite` or `memwrite` pulse.
- Assert `reset` asynchronously in MEMREAD: outputs switch to FETCH values before the next edge. After release, the lw sequence restarts from DECODE.
